// File: rtl/parking_lot_ctrl.sv
// Parking lot controller: tracks spot occupancy, per-spot dwell timers,
// entry/exit handshakes and a timed entry door driven by a 1 s tick.
module parking_lot_ctrl #(
    parameter int NUM_SPOTS  = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int DOOR_TICKS = 3,
    localparam int SW = $clog2(NUM_SPOTS),
    localparam int CW = $clog2(NUM_SPOTS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_entry_req,
    input  logic                 i_exit_req,
    input  logic [SW-1:0]        i_exit_slot,
    output logic [NUM_SPOTS-1:0] o_spots,
    output logic [CW-1:0]        o_capacity,
    output logic [SW-1:0]        o_location,
    output logic                 o_is_full,
    output logic                 o_is_open,
    output logic                 o_entry_ack,
    output logic                 o_entry_nack,
    output logic                 o_exit_ack,
    output logic                 o_exit_err,
    output logic [5:0]           o_minutes,
    output logic [5:0]           o_seconds
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DOOR_TICKS + 1);

    typedef enum logic {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } door_state_t;

    logic [TW-1:0]        r_tick_cnt;
    logic [NUM_SPOTS-1:0] r_spots;
    logic [5:0]           r_min [NUM_SPOTS];
    logic [5:0]           r_sec [NUM_SPOTS];
    logic [5:0]           r_minutes;
    logic [5:0]           r_seconds;
    logic                 r_entry_ack;
    logic                 r_entry_nack;
    logic                 r_exit_ack;
    logic                 r_exit_err;
    door_state_t          r_door;
    logic [DW-1:0]        r_door_cnt;

    logic                 w_tick;
    logic [CW-1:0]        w_free_cnt;
    logic [SW-1:0]        w_location;
    logic                 w_full;
    logic                 w_entry_ok;
    logic                 w_exit_ok;
    logic [5:0]           w_exit_min;
    logic [5:0]           w_exit_sec;

    assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_full     = (w_free_cnt == '0);
    assign w_entry_ok = i_entry_req && !w_full;

    // Free-spot count, lowest free index, and the exiting spot's validity/timer.
    always_comb begin
        w_free_cnt = '0;
        w_location = '0;
        w_exit_ok  = 1'b0;
        w_exit_min = '0;
        w_exit_sec = '0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!r_spots[i]) begin
                w_location = SW'(i);
                w_free_cnt = w_free_cnt + CW'(1);
            end
            if (i_exit_req && r_spots[i] && (i_exit_slot == SW'(i))) begin
                w_exit_ok  = 1'b1;
                w_exit_min = r_min[i];
                w_exit_sec = r_sec[i];
            end
        end
    end

    // Free-running 1 s tick divider.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Occupancy, dwell timers, result pulses and latched dwell time.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_spots      <= '0;
            r_minutes    <= '0;
            r_seconds    <= '0;
            r_entry_ack  <= 1'b0;
            r_entry_nack <= 1'b0;
            r_exit_ack   <= 1'b0;
            r_exit_err   <= 1'b0;
            for (int i = 0; i < NUM_SPOTS; i++) begin
                r_min[i] <= '0;
                r_sec[i] <= '0;
            end
        end else begin
            r_entry_ack  <= w_entry_ok;
            r_entry_nack <= i_entry_req && w_full;
            r_exit_ack   <= w_exit_ok;
            r_exit_err   <= i_exit_req && !w_exit_ok;
            for (int i = 0; i < NUM_SPOTS; i++) begin
                if (w_tick && r_spots[i]) begin
                    if (r_sec[i] != 6'd59) begin
                        r_sec[i] <= r_sec[i] + 6'd1;
                    end else if (r_min[i] != 6'd59) begin
                        r_sec[i] <= '0;
                        r_min[i] <= r_min[i] + 6'd1;
                    end
                end
            end
            // The entry spot is free, so it never collides with the exit spot;
            // placed after the tick update so a same-cycle clear wins.
            if (w_entry_ok) begin
                r_spots[w_location] <= 1'b1;
                r_min[w_location]   <= '0;
                r_sec[w_location]   <= '0;
            end
            if (w_exit_ok) begin
                r_spots[i_exit_slot] <= 1'b0;
                r_minutes            <= w_exit_min;
                r_seconds            <= w_exit_sec;
            end
        end
    end

    // Door FSM: opens on accepted entry, closes after DOOR_TICKS ticks idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_door     <= CLOSED;
            r_door_cnt <= '0;
        end else if (w_entry_ok) begin
            r_door     <= OPEN;
            r_door_cnt <= DW'(DOOR_TICKS);
        end else if (r_door == OPEN && w_tick) begin
            r_door_cnt <= r_door_cnt - DW'(1);
            if (r_door_cnt == DW'(1)) begin
                r_door <= CLOSED;
            end
        end
    end

    assign o_spots      = r_spots;
    assign o_capacity   = w_free_cnt;
    assign o_location   = w_location;
    assign o_is_full    = w_full;
    assign o_is_open    = (r_door == OPEN);
    assign o_entry_ack  = r_entry_ack;
    assign o_entry_nack = r_entry_nack;
    assign o_exit_ack   = r_exit_ack;
    assign o_exit_err   = r_exit_err;
    assign o_minutes    = r_minutes;
    assign o_seconds    = r_seconds;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Bench for parking_lot_ctrl: directed vectors, a behavioural model in whole
// seconds compared every cycle, and literal expectations for key scenarios.
module tb_parking_lot_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int DT = 2;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_entry_req = 1'b0;
    logic       i_exit_req = 1'b0;
    logic [1:0] i_exit_slot = '0;
    logic [3:0] o_spots;
    logic [2:0] o_capacity;
    logic [1:0] o_location;
    logic       o_is_full, o_is_open;
    logic       o_entry_ack, o_entry_nack, o_exit_ack, o_exit_err;
    logic [5:0] o_minutes, o_seconds;

    parking_lot_ctrl #(.NUM_SPOTS(N), .TICK_DIV(TD), .DOOR_TICKS(DT)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_entry_req(i_entry_req),
        .i_exit_req(i_exit_req), .i_exit_slot(i_exit_slot),
        .o_spots(o_spots), .o_capacity(o_capacity), .o_location(o_location),
        .o_is_full(o_is_full), .o_is_open(o_is_open),
        .o_entry_ack(o_entry_ack), .o_entry_nack(o_entry_nack),
        .o_exit_ack(o_exit_ack), .o_exit_err(o_exit_err),
        .o_minutes(o_minutes), .o_seconds(o_seconds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model state: dwell kept as total seconds, door as remaining ticks
    bit m_occ [N];
    int m_dwell [N];
    int m_tick_cnt, m_door, m_last;
    bit m_eack, m_enack, m_xack, m_xerr;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit ex, input int slot);
        bit tick;
        int free_idx;
        if (rst) begin
            foreach (m_occ[i]) begin m_occ[i] = 0; m_dwell[i] = 0; end
            m_tick_cnt = 0; m_door = 0; m_last = 0;
            m_eack = 0; m_enack = 0; m_xack = 0; m_xerr = 0;
            return;
        end
        tick = (m_tick_cnt == TD - 1);
        free_idx = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_occ[i]) free_idx = i;
        m_eack  = en && free_idx >= 0;
        m_enack = en && free_idx < 0;
        m_xack  = ex && slot < N && m_occ[slot];
        m_xerr  = ex && !m_xack;
        if (m_xack) m_last = m_dwell[slot];
        for (int i = 0; i < N; i++)
            if (tick && m_occ[i] && m_dwell[i] < 3599) m_dwell[i]++;
        if (m_eack) begin m_occ[free_idx] = 1; m_dwell[free_idx] = 0; end
        if (m_xack) m_occ[slot] = 0;
        if (m_eack) m_door = DT;
        else if (tick && m_door > 0) m_door--;
        m_tick_cnt = (m_tick_cnt + 1) % TD;
    endtask

    task automatic compare();
        int spots, used, loc;
        spots = 0; used = 0; loc = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_occ[i]) begin spots |= (1 << i); used++; end
            else loc = i;
        end
        chk("spots", int'(o_spots), spots);
        chk("capacity", int'(o_capacity), N - used);
        chk("location", int'(o_location), loc);
        chk("is_full", int'(o_is_full), int'(used == N));
        chk("is_open", int'(o_is_open), int'(m_door > 0));
        chk("entry_ack", int'(o_entry_ack), int'(m_eack));
        chk("entry_nack", int'(o_entry_nack), int'(m_enack));
        chk("exit_ack", int'(o_exit_ack), int'(m_xack));
        chk("exit_err", int'(o_exit_err), int'(m_xerr));
        chk("minutes", int'(o_minutes), m_last / 60);
        chk("seconds", int'(o_seconds), m_last % 60);
    endtask

    task automatic step(input bit rst, input bit en, input bit ex, input int slot);
        i_reset = rst; i_entry_req = en; i_exit_req = ex; i_exit_slot = 2'(slot);
        @(posedge clk);
        model_edge(rst, en, ex, slot);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    initial begin
        #1;
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("lit_rst_capacity", int'(o_capacity), 4);
        chk("lit_rst_open", int'(o_is_open), 0);

        // fill the lot, then one more
        step(0, 1, 0, 0); chk("lit_fill1", int'(o_spots), 4'b0001); chk("lit_cap1", int'(o_capacity), 3);
        step(0, 1, 0, 0); chk("lit_fill2", int'(o_spots), 4'b0011); chk("lit_cap2", int'(o_capacity), 2);
        step(0, 1, 0, 0); chk("lit_fill3", int'(o_spots), 4'b0111); chk("lit_cap3", int'(o_capacity), 1);
        step(0, 1, 0, 0); chk("lit_fill4", int'(o_spots), 4'b1111); chk("lit_full", int'(o_is_full), 1);
        step(0, 1, 0, 0); chk("lit_nack", int'(o_entry_nack), 1); chk("lit_fill5", int'(o_spots), 4'b1111);

        // dwell of 10 ticks
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        idle(10 * TD);
        step(0, 0, 1, 0);
        chk("lit_dwell_ack", int'(o_exit_ack), 1);
        chk("lit_dwell_sec", int'(o_seconds), 10);
        chk("lit_dwell_min", int'(o_minutes), 0);
        chk("lit_dwell_spots", int'(o_spots), 0);

        // exits of unoccupied slots
        step(0, 0, 1, 2); chk("lit_err2", int'(o_exit_err), 1);
        step(0, 0, 1, 3); chk("lit_err3", int'(o_exit_err), 1); chk("lit_err_sec", int'(o_seconds), 10);

        // simultaneous entry/exit on a full lot
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
        idle(3);
        step(0, 1, 1, 1);
        chk("lit_sim_nack", int'(o_entry_nack), 1);
        chk("lit_sim_xack", int'(o_exit_ack), 1);
        chk("lit_sim_spots", int'(o_spots), 4'b1101);
        step(0, 1, 0, 0); chk("lit_refill", int'(o_spots), 4'b1111);
        idle(5);
        step(0, 0, 1, 3);
        idle(2);

        // door reload and close timing
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); chk("lit_door_open", int'(o_is_open), 1);
        idle(TD);
        step(0, 1, 0, 0);
        idle(TD); chk("lit_door_still", int'(o_is_open), 1);
        idle(2 * TD); chk("lit_door_closed", int'(o_is_open), 0);

        // saturation at 59:59, then exit
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        idle(3610 * TD);
        step(0, 0, 1, 0);
        chk("lit_sat_min", int'(o_minutes), 59);
        chk("lit_sat_sec", int'(o_seconds), 59);

        // reset with door open and spots occupied, request pending
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("lit_mid_spots", int'(o_spots), 0);
        chk("lit_mid_open", int'(o_is_open), 0);
        chk("lit_mid_sec", int'(o_seconds), 0);
        chk("lit_mid_ack", int'(o_entry_ack), 0);
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
